seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clock cycles per digit slot; legal range is 2 or greater.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, dead-time cycles at the start of each digit slot; legal range is 0 to CLK_DIV-1.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1; a value of 1 means a segment is lit when its seg_o bit is 0.
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 1; a value of 1 means a digit is enabled when its an_o bit is 0.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  scan enable.
REQ-009 seg_i  input  64  logical (1 = lit) segment patterns; digit k is seg_i[8k+7:8k], taken from the per-digit outputs of the hex decoder stage.
REQ-010 seg_o  output  8  physical segment drive for the currently scanned digit.
REQ-011 an_o  output  8  physical digit-enable (anode) drive, one-hot when active.
REQ-012 digit_o  output  3  index of the current digit slot.
REQ-013 frame_o  output  1  single-cycle pulse at each frame boundary.

Function
REQ-014 Every output SHALL be driven directly from a register.
REQ-015 "Off" SHALL mean a logical 0 mapped to the physical level by the polarity parameters: seg off = 8'hFF when SEG_ACTIVE_LOW=1, else 8'h00; an off follows AN_ACTIVE_LOW the same way.
REQ-016 The FSM SHALL have three states: IDLE, BLANK and SHOW.
REQ-017 IDLE SHALL hold seg_o off, an_o off, digit_o 0 and frame_o 0.
REQ-018 IDLE -> start of digit 0 SHALL occur on the first edge that samples en=1; at that edge the 64-bit snapshot register SHALL capture seg_i.
REQ-019 Each digit slot SHALL last exactly CLK_DIV cycles: BLANK_CYCLES cycles in BLANK, then CLK_DIV-BLANK_CYCLES cycles in SHOW.
REQ-020 BLANK_CYCLES=0 SHALL skip BLANK entirely, entering SHOW directly.
REQ-021 BLANK SHALL drive seg_o and an_o off, with digit_o holding the slot index.
REQ-022 SHOW SHALL drive an_o one-hot at bit digit_o (polarity applied) and seg_o from snapshot digit digit_o (polarity applied).
REQ-023 At the end of a slot, digit_o SHALL increment modulo 8.
REQ-024 A 7 -> 0 wrap SHALL recapture the snapshot from seg_i and pulse frame_o high for exactly that one cycle.
REQ-025 Changes on seg_i SHALL NOT affect displayed data until the next snapshot, so there is no tearing within a frame.
REQ-026 en sampled 0 in any state SHALL move to IDLE on that edge, with outputs off on the same edge.
REQ-027 Re-enabling SHALL always restart at digit 0 with a fresh snapshot.
REQ-028 The slot counter SHALL be sized $clog2(CLK_DIV) bits and SHALL reset to 0 at every slot boundary; it SHALL never wrap otherwise.

Reset
REQ-029 rst=1 SHALL, with no clock edge required, force state IDLE, counter 0, digit_o 0, frame_o 0, snapshot 0, and seg_o/an_o off.
REQ-030 Reset asserted mid-slot SHALL abandon the slot; after release, operation SHALL resume via REQ-018 only.

Structure
REQ-031 State encodings and the off-level constants SHALL live in the shared package seg_scan_pkg.
REQ-032 The block SHALL be a single module; no sub-module is warranted.

Verification (CLK_DIV=8, BLANK_CYCLES=2, active-low unless stated)
REQ-033 Assert rst with no clock -> an_o=8'hFF, seg_o=8'hFF, digit_o=0, frame_o=0 immediately.
REQ-034 en=1, digit k pattern = k+1 -> 2 cycles off, then 6 cycles an_o=8'hFE, seg_o=8'hFE; next slot an_o=8'hFD, seg_o=8'hFD; frame_o high once every 64 cycles.
REQ-035 Change seg_i during digit 3 of a frame -> displayed patterns are unchanged until after the next frame_o pulse.
REQ-036 en=0 during SHOW of digit 5 -> next edge an_o=8'hFF, digit_o=0; en=1 again -> scan restarts at digit 0.
REQ-037 Assert rst asynchronously mid-SHOW -> outputs off before the next edge; after release with en=1, scanning starts at digit 0.
REQ-038 BLANK_CYCLES=0 with both polarity parameters 0 -> an_o=8'h01 for 8 cycles, then 8'h02, with no off gap.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver:
// the FSM state encoding and the mapping from logical to physical drive levels.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam logic [7:0] OFF_LVL_ACTIVE_LOW  = 8'hFF;
  localparam logic [7:0] OFF_LVL_ACTIVE_HIGH = 8'h00;

  // Logical 1 = lit/enabled; an active-low pin inverts that.
  function automatic logic [7:0] to_phys(input logic [7:0] v, input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scanner: each digit slot has a blanked
// dead-time followed by a show window; the digit data is snapshotted once per frame.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] seg_i,
  output logic [7:0]  seg_o,
  output logic [7:0]  an_o,
  output logic [2:0]  digit_o,
  output logic        frame_o
);

  localparam int            CW          = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLK_DIV - 1);
  localparam logic [7:0]    SEG_OFF     = SEG_ACTIVE_LOW ? OFF_LVL_ACTIVE_LOW : OFF_LVL_ACTIVE_HIGH;
  localparam logic [7:0]    AN_OFF      = AN_ACTIVE_LOW  ? OFF_LVL_ACTIVE_LOW : OFF_LVL_ACTIVE_HIGH;
  localparam scan_state_t   SLOT_START  = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  scan_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    digit_reg, digit_next;
  logic [63:0]   snap_reg, snap_next;
  logic          frame_next;
  logic [7:0]    seg_next, an_next;
  logic [7:0]    seg_reg, an_reg;
  logic          frame_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    digit_next = digit_reg;
    snap_next  = snap_reg;
    frame_next = 1'b0;

    if (!en) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      digit_next = 3'd0;
    end else if (state_reg == ST_IDLE) begin
      state_next = SLOT_START;
      cnt_next   = '0;
      digit_next = 3'd0;
      snap_next  = seg_i;
    end else if (cnt_reg == CNT_LAST) begin
      state_next = SLOT_START;
      cnt_next   = '0;
      digit_next = digit_reg + 3'd1;
      if (digit_reg == 3'd7) begin
        snap_next  = seg_i;
        frame_next = 1'b1;
      end
    end else begin
      cnt_next   = cnt_reg + 1'b1;
      state_next = (int'(cnt_next) < BLANK_CYCLES) ? ST_BLANK : ST_SHOW;
    end

    // Outputs are computed from the next-state values so the registered
    // drive lines up with the state it belongs to, including the first SHOW
    // cycle right after a fresh snapshot.
    if (state_next == ST_SHOW) begin
      seg_next = to_phys(snap_next[{digit_next, 3'b000} +: 8], SEG_ACTIVE_LOW);
      an_next  = to_phys(8'b1 << digit_next, AN_ACTIVE_LOW);
    end else begin
      seg_next = SEG_OFF;
      an_next  = AN_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      digit_reg <= 3'd0;
      snap_reg  <= '0;
      frame_reg <= 1'b0;
      seg_reg   <= SEG_OFF;
      an_reg    <= AN_OFF;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      digit_reg <= digit_next;
      snap_reg  <= snap_next;
      frame_reg <= frame_next;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
    end
  end

  assign seg_o   = seg_reg;
  assign an_o    = an_reg;
  assign digit_o = digit_reg;
  assign frame_o = frame_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver: two instances (blanked active-low, and
// unblanked active-high) checked every cycle against an elapsed-time model.
module tb_seg_scan_driver;

  localparam int CD    = 8;
  localparam int BL_A  = 2;
  localparam int BL_B  = 0;
  localparam int FRAME = 8 * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [63:0] seg_i = '0;

  logic [7:0] seg_a, an_a, seg_b, an_b;
  logic [2:0] digit_a, digit_b;
  logic       frame_a, frame_b;

  int total = 0;
  int bad   = 0;

  seg_scan_driver #(.CLK_DIV(CD), .BLANK_CYCLES(BL_A), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .seg_i(seg_i),
    .seg_o(seg_a), .an_o(an_a), .digit_o(digit_a), .frame_o(frame_a)
  );

  seg_scan_driver #(.CLK_DIV(CD), .BLANK_CYCLES(BL_B), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .seg_i(seg_i),
    .seg_o(seg_b), .an_o(an_b), .digit_o(digit_b), .frame_o(frame_b)
  );

  always #5 clk = ~clk;

  // Model: whether scanning, cycles elapsed since the scan started, and the
  // pattern captured at the last frame start.
  bit          m_active = 1'b0;
  int          m_t      = 0;
  logic [63:0] m_snap   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_snap   <= '0;
    end else if (!en) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end else if (!m_active) begin
      m_active <= 1'b1;
      m_t      <= 0;
      m_snap   <= seg_i;
    end else begin
      m_t <= m_t + 1;
      if ((m_t + 1) % FRAME == 0) m_snap <= seg_i;
    end
  end

  function automatic logic [7:0] phys(input logic [7:0] v, input bit active_low);
    return active_low ? ~v : v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string name, input logic [7:0] seg, input logic [7:0] an,
                           input logic [2:0] dig, input logic frm, input int blank, input bit al);
    logic [7:0] e_seg, e_an;
    logic [2:0] e_dig;
    logic       e_frm;
    int         pos, d;
    e_seg = phys(8'h00, al);
    e_an  = phys(8'h00, al);
    e_dig = 3'd0;
    e_frm = 1'b0;
    if (m_active) begin
      pos   = m_t % CD;
      d     = (m_t / CD) % 8;
      e_dig = 3'(d);
      e_frm = (m_t > 0) && (m_t % FRAME == 0);
      if (pos >= blank) begin
        e_seg = phys(m_snap[d*8 +: 8], al);
        e_an  = phys(8'(1 << d), al);
      end
    end
    check({name, ".seg"},   64'(seg), 64'(e_seg));
    check({name, ".an"},    64'(an),  64'(e_an));
    check({name, ".digit"}, 64'(dig), 64'(e_dig));
    check({name, ".frame"}, 64'(frm), 64'(e_frm));
  endtask

  task automatic check_all();
    check_dut("a", seg_a, an_a, digit_a, frame_a, BL_A, 1'b1);
    check_dut("b", seg_b, an_b, digit_b, frame_b, BL_B, 1'b0);
  endtask

  // Advance one cycle and check outputs on the falling edge.
  task automatic step();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1 check_all();
    check("async_rst.an_a", 64'(an_a), 64'hFF);
    #1 rst = 1'b0;
  endtask

  initial begin
    int frames;
    int guard;

    // Reset with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    check("rst.an_a",    64'(an_a),    64'hFF);
    check("rst.seg_a",   64'(seg_a),   64'hFF);
    check("rst.digit_a", 64'(digit_a), 64'h0);
    check("rst.frame_a", 64'(frame_a), 64'h0);
    check("rst.an_b",    64'(an_b),    64'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset phase: total=%0d", total);

    // Directed pattern: digit k shows k+1.
    for (int k = 0; k < 8; k++) seg_i[k*8 +: 8] = 8'(k + 1);
    en = 1'b1;
    step(); step(); step();
    check("dir.an_a.d0",  64'(an_a),  64'hFE);
    check("dir.seg_a.d0", 64'(seg_a), 64'hFE);
    for (int i = 0; i < 8; i++) step();
    check("dir.an_a.d1",  64'(an_a),  64'hFD);
    check("dir.seg_a.d1", 64'(seg_a), 64'hFD);
    frames = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame_a) frames++;
    end
    check("dir.frames", 64'(frames), 64'd2);
    $display("directed pattern phase: total=%0d", total);

    // Drop en during SHOW of digit 5, then re-enable.
    guard = 0;
    while (!(m_active && ((m_t / CD) % 8 == 5) && (m_t % CD == 4)) && guard < 200) begin
      step();
      guard++;
    end
    check("find_d5_show", 64'(guard < 200), 64'd1);
    en = 1'b0;
    step();
    check("en_drop.an_a",    64'(an_a),    64'hFF);
    check("en_drop.digit_a", 64'(digit_a), 64'h0);
    en = 1'b1;
    for (int i = 0; i < 20; i++) step();
    $display("enable drop phase: total=%0d", total);

    // Asynchronous reset mid-SHOW, then restart.
    async_reset_pulse();
    for (int i = 0; i < 20; i++) step();
    $display("async reset phase: total=%0d", total);

    // Randomized: seg_i churns within frames, occasional en drops and resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) seg_i = {$urandom, $urandom};
      if ($urandom_range(0, 149) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
      if ($urandom_range(0, 399) == 0) async_reset_pulse();
    end
    $display("random phase: total=%0d", total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
